// File: rtl/cwave_tone_det.sv
// Three-bin Goertzel tone analyzer: accumulates N-sample blocks, then reports
// per-bin power and threshold-detect flags with a one-cycle out_valid pulse.
module cwave_tone_det #(
  parameter int unsigned N         = 200,
  parameter int unsigned IN_W      = 16,
  parameter int unsigned ACC_W     = 40,
  parameter int          COEF0     = 32752,
  parameter int          COEF1     = 29197,
  parameter int          COEF2     = 0,
  parameter int unsigned PWR_SHIFT = 0,
  parameter logic [47:0] THRESH    = 48'd1_000_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic signed [IN_W-1:0] in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [47:0]            pwr0,
  output logic [47:0]            pwr1,
  output logic [47:0]            pwr2,
  output logic [2:0]             det
);

  localparam int unsigned CNT_W  = $clog2(N);
  localparam int unsigned COEF_W = 18;
  localparam int unsigned FRAC_W = 14;
  localparam int unsigned PROD_W = ACC_W + COEF_W;
  localparam int unsigned PW_W   = 2 * ACC_W + COEF_W + 2;
  localparam int unsigned PWR_W  = 48;
  localparam int unsigned NB     = 3;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ACC  = 3'd1;
  localparam logic [2:0] S_PWR0 = 3'd2;
  localparam logic [2:0] S_PWR1 = 3'd3;
  localparam logic [2:0] S_PWR2 = 3'd4;
  localparam logic [2:0] S_OUT  = 3'd5;

  logic [2:0]               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  s1_q [NB];
  logic signed [ACC_W-1:0]  s1_d [NB];
  logic signed [ACC_W-1:0]  s2_q [NB];
  logic signed [ACC_W-1:0]  s2_d [NB];
  logic [PWR_W-1:0]         shd_q [NB];
  logic [PWR_W-1:0]         shd_d [NB];
  logic [PWR_W-1:0]         pwr_q [NB];
  logic [PWR_W-1:0]         pwr_d [NB];
  logic [NB-1:0]            det_q, det_d;
  logic                     out_valid_q, out_valid_d;
  logic                     in_ready_q, in_ready_d;

  logic [1:0]               pbin;
  logic signed [PW_W-1:0]   pa, pb, pc, raw, raw_sh;
  logic [PWR_W-1:0]         pwr_sat;

  function automatic logic signed [COEF_W-1:0] coef_of(input logic [1:0] b);
    case (b)
      2'd0:    coef_of = COEF_W'(COEF0);
      2'd1:    coef_of = COEF_W'(COEF1);
      default: coef_of = COEF_W'(COEF2);
    endcase
  endfunction

  // Power of the bin selected by the current PWR state, shifted and saturated
  always_comb begin
    case (state_q)
      S_PWR1:  pbin = 2'd1;
      S_PWR2:  pbin = 2'd2;
      default: pbin = 2'd0;
    endcase
    pa     = PW_W'(s1_q[pbin]);
    pb     = PW_W'(s2_q[pbin]);
    pc     = PW_W'(coef_of(pbin));
    raw    = pa * pa + pb * pb - ((pc * pa * pb) >>> FRAC_W);
    raw_sh = raw >>> PWR_SHIFT;
    if (raw_sh[PW_W-1]) begin
      pwr_sat = '0;
    end else if (|raw_sh[PW_W-2:PWR_W]) begin
      pwr_sat = '1;
    end else begin
      pwr_sat = raw_sh[PWR_W-1:0];
    end
  end

  // Next-state and datapath updates; en low overrides everything back to IDLE
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    shd_d       = shd_q;
    pwr_d       = pwr_q;
    det_d       = det_q;
    out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        for (int unsigned i = 0; i < NB; i++) begin
          s1_d[i] = '0;
          s2_d[i] = '0;
        end
        state_d = S_ACC;
      end
      S_ACC: begin
        if (in_valid) begin
          for (int unsigned i = 0; i < NB; i++) begin
            s2_d[i] = s1_q[i];
            s1_d[i] = ACC_W'(in_data)
                    + ACC_W'((PROD_W'(coef_of(2'(i))) * PROD_W'(s1_q[i])) >>> FRAC_W)
                    - s2_q[i];
          end
          if (cnt_q == CNT_W'(N - 1)) begin
            cnt_d   = '0;
            state_d = S_PWR0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_PWR0: begin
        shd_d[0] = pwr_sat;
        state_d  = S_PWR1;
      end
      S_PWR1: begin
        shd_d[1] = pwr_sat;
        state_d  = S_PWR2;
      end
      S_PWR2: begin
        shd_d[2] = pwr_sat;
        state_d  = S_OUT;
      end
      S_OUT: begin
        for (int unsigned i = 0; i < NB; i++) begin
          pwr_d[i] = shd_q[i];
          det_d[i] = shd_q[i] > THRESH;
          s1_d[i]  = '0;
          s2_d[i]  = '0;
        end
        cnt_d       = '0;
        out_valid_d = 1'b1;
        state_d     = S_ACC;
      end
      default: state_d = S_IDLE;
    endcase

    if (!en) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      pwr_d       = pwr_q;
      det_d       = det_q;
    end

    in_ready_d = (state_d == S_ACC);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      det_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      for (int unsigned i = 0; i < NB; i++) begin
        s1_q[i]  <= '0;
        s2_q[i]  <= '0;
        shd_q[i] <= '0;
        pwr_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      det_q       <= det_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      for (int unsigned i = 0; i < NB; i++) begin
        s1_q[i]  <= s1_d[i];
        s2_q[i]  <= s2_d[i];
        shd_q[i] <= shd_d[i];
        pwr_q[i] <= pwr_d[i];
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign pwr0      = pwr_q[0];
  assign pwr1      = pwr_q[1];
  assign pwr2      = pwr_q[2];
  assign det       = det_q;

endmodule

// File: tb/tb_cwave_tone_det.sv
// Bench for cwave_tone_det: block-level Goertzel reference over a queue of
// accepted samples, checked every cycle plus directed tone/impulse sanity checks.
module tb_cwave_tone_det;

  localparam int          N      = 200;
  localparam logic [47:0] THRESH = 48'd1_000_000_000;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               in_ready;
  logic               out_valid;
  logic [47:0]        pwr0, pwr1, pwr2;
  logic [2:0]         det;

  always #5 clk = ~clk;

  cwave_tone_det dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .pwr0     (pwr0),
    .pwr1     (pwr1),
    .pwr2     (pwr2),
    .det      (det)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: phase 0 idle, 1 accumulating, 2..5 the four result cycles
  int          m_phase;
  bit          m_ready, m_ov;
  logic [47:0] m_pwr  [3];
  logic [47:0] m_pend [3];
  logic [2:0]  m_det;
  int          blk  [$];
  int          stim [$];
  int          coefs [3] = '{32752, 29197, 0};
  int          ov_seen;

  function automatic longint wrap40(input longint x);
    return (x <<< 24) >>> 24;
  endfunction

  // Goertzel over the whole accepted block, then power with clamp to 48 bits
  function automatic logic [47:0] bin_power(input int coef);
    longint s1, s2, s;
    logic signed [127:0] a, b, c, r;
    s1 = 0;
    s2 = 0;
    foreach (blk[k]) begin
      s  = wrap40(longint'(blk[k]) + ((longint'(coef) * s1) >>> 14) - s2);
      s2 = s1;
      s1 = s;
    end
    a = s1;
    b = s2;
    c = coef;
    r = a * a + b * b - ((c * a * b) >>> 14);
    if (r < 0) return 48'd0;
    if (r[127:48] != 0) return '1;
    return r[47:0];
  endfunction

  task automatic model_step(input bit e, input bit v, input logic signed [15:0] d);
    int nxt;
    m_ov = 1'b0;
    nxt  = m_phase;
    if (m_phase == 1 && v) blk.push_back(int'(d));
    if (!e) begin
      nxt = 0;
      blk.delete();
    end else begin
      case (m_phase)
        0: begin
          blk.delete();
          nxt = 1;
        end
        1: if (blk.size() == N) begin
          for (int i = 0; i < 3; i++) m_pend[i] = bin_power(coefs[i]);
          nxt = 2;
        end
        2, 3, 4: nxt = m_phase + 1;
        default: begin
          m_ov = 1'b1;
          for (int i = 0; i < 3; i++) begin
            m_pwr[i] = m_pend[i];
            m_det[i] = m_pend[i] > THRESH;
          end
          blk.delete();
          nxt = 1;
        end
      endcase
    end
    m_phase = nxt;
    m_ready = (nxt == 1);
  endtask

  task automatic check_outputs();
    if (out_valid === 1'b1) ov_seen++;
    check("in_ready", in_ready, m_ready);
    check("out_valid", out_valid, m_ov);
    check("pwr0", pwr0, m_pwr[0]);
    check("pwr1", pwr1, m_pwr[1]);
    check("pwr2", pwr2, m_pwr[2]);
    check("det", det, m_det);
  endtask

  // One clock: drive at negedge, advance reference, sample at the next negedge
  task automatic cycle(input bit e, input bit v, input logic signed [15:0] d);
    en       = e;
    in_valid = v;
    in_data  = d;
    model_step(e, v, d);
    @(negedge clk);
    check_outputs();
  endtask

  // gap: 0 none, 1 every other ACC cycle idle, 2 random idle cycles
  task automatic send_block(input int gap);
    int idx, guard;
    bit tgl;
    idx   = 0;
    guard = 0;
    tgl   = 1'b0;
    while (idx < stim.size()) begin
      if (m_phase != 1) begin
        cycle(1'b1, 1'b1, 16'($urandom));
      end else if ((gap == 1 && tgl) || (gap == 2 && $urandom_range(0, 2) == 0)) begin
        cycle(1'b1, 1'b0, 16'($urandom));
        tgl = ~tgl;
      end else begin
        cycle(1'b1, 1'b1, 16'(stim[idx]));
        idx++;
        tgl = ~tgl;
      end
      guard++;
      if (guard > 5000) begin
        check("send_guard", 64'd0, 64'd1);
        break;
      end
    end
  endtask

  // Offer samples through the result cycles and time the out_valid pulse
  task automatic drain();
    int k, ov_at;
    k     = 0;
    ov_at = -1;
    while (m_phase != 1 && k < 10) begin
      cycle(1'b1, 1'b1, 16'($urandom));
      k++;
      if (out_valid === 1'b1 && ov_at < 0) ov_at = k;
    end
    check("ov_latency", 64'(ov_at), 64'd4);
  endtask

  task automatic fill_random(input int len, input int amp);
    stim.delete();
    for (int i = 0; i < len; i++) stim.push_back(int'($urandom_range(0, 2 * amp)) - amp);
  endtask

  logic [47:0] imp_ref [3];
  int          ov_before;

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    m_phase  = 0;
    m_ready  = 1'b0;
    m_ov     = 1'b0;
    m_det    = '0;
    ov_seen  = 0;
    for (int i = 0; i < 3; i++) begin
      m_pwr[i]  = '0;
      m_pend[i] = '0;
    end

    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_pwr0", pwr0, 48'd0);
    check("rst_pwr1", pwr1, 48'd0);
    check("rst_pwr2", pwr2, 48'd0);
    check("rst_det", det, 3'd0);
    rst_n = 1'b1;
    repeat (2) cycle(1'b0, 1'b0, 16'd0);

    // All-zero block
    stim.delete();
    for (int i = 0; i < N; i++) stim.push_back(0);
    send_block(0);
    drain();
    check("zero_pwr0", pwr0, 48'd0);
    check("zero_pwr1", pwr1, 48'd0);
    check("zero_pwr2", pwr2, 48'd0);
    check("zero_det", det, 3'd0);

    // Impulse of 1000
    stim.delete();
    stim.push_back(1000);
    for (int i = 1; i < N; i++) stim.push_back(0);
    send_block(0);
    drain();
    for (int i = 0; i < 3; i++) imp_ref[i] = m_pwr[i];
    check("imp_pwr0_near_1e6", 64'(pwr0 >= 48'd980_000 && pwr0 <= 48'd1_020_000), 64'd1);
    check("imp_pwr1_near_1e6", 64'(pwr1 >= 48'd980_000 && pwr1 <= 48'd1_020_000), 64'd1);
    check("imp_pwr2_exact", pwr2, 48'd1_000_000);
    check("imp_det", det, 3'd0);

    // Same impulse with every other cycle idle
    send_block(1);
    drain();
    check("gap_pwr0", pwr0, imp_ref[0]);
    check("gap_pwr1", pwr1, imp_ref[1]);
    check("gap_pwr2", pwr2, imp_ref[2]);

    // 50 kHz tone: 0, 8192, 0, -8192
    stim.delete();
    for (int i = 0; i < N; i++) stim.push_back((i % 4 == 1) ? 8192 : (i % 4 == 3) ? -8192 : 0);
    send_block(0);
    drain();
    check("tone_pwr2", pwr2, 48'd671_088_640_000);
    check("tone_pwr0_low", 64'(pwr0 < 48'd1_000_000), 64'd1);
    check("tone_pwr1_low", 64'(pwr1 < 48'd1_000_000), 64'd1);
    check("tone_det", det, 3'b100);

    // Abort at sample 100, then a fresh block
    ov_before = ov_seen;
    fill_random(100, 20000);
    send_block(0);
    cycle(1'b0, 1'b1, 16'($urandom));
    check("abort_pwr2_held", pwr2, 48'd671_088_640_000);
    fill_random(N, 20000);
    send_block(2);
    check("abort_no_ov", 64'(ov_seen - ov_before), 64'd0);
    drain();
    check("abort_one_ov", 64'(ov_seen - ov_before), 64'd1);

    // en dropped together with the final sample: no result
    ov_before = ov_seen;
    fill_random(N - 1, 30000);
    send_block(0);
    cycle(1'b0, 1'b1, 16'sd1234);
    repeat (8) cycle(1'b0, 1'b1, 16'($urandom));
    check("final_abort_no_ov", 64'(ov_seen - ov_before), 64'd0);

    // Random blocks with varied amplitude and gap patterns
    for (int b = 0; b < 5; b++) begin
      fill_random(N, (b == 4) ? 32767 : int'($urandom_range(1, 32767)));
      send_block(b % 3);
      drain();
    end

    // Reset in the middle of a block
    fill_random(50, 10000);
    send_block(0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1'b0);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_pwr0", pwr0, 48'd0);
    check("mid_rst_pwr1", pwr1, 48'd0);
    check("mid_rst_pwr2", pwr2, 48'd0);
    check("mid_rst_det", det, 3'd0);
    m_phase = 0;
    m_ready = 1'b0;
    m_ov    = 1'b0;
    m_det   = '0;
    blk.delete();
    for (int i = 0; i < 3; i++) m_pwr[i] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fill_random(N, 15000);
    send_block(2);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
